// File: rtl/bram_sp_arbiter_if.sv
// Request/response channels of both clients plus the single-port RAM port.
// The slave modport is the arbiter's view; master is the client/RAM side.
interface bram_sp_arbiter_if #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 32
);
  logic          s0_req_valid;
  logic          s0_req_ready;
  logic          s0_req_wen;
  logic [AW-1:0] s0_req_addr;
  logic [DW-1:0] s0_req_wdata;
  logic          s0_rsp_valid;
  logic [DW-1:0] s0_rsp_rdata;

  logic          s1_req_valid;
  logic          s1_req_ready;
  logic          s1_req_wen;
  logic [AW-1:0] s1_req_addr;
  logic [DW-1:0] s1_req_wdata;
  logic          s1_rsp_valid;
  logic [DW-1:0] s1_rsp_rdata;

  logic          m_en;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;

  modport slave (
    input  s0_req_valid, s0_req_wen, s0_req_addr, s0_req_wdata,
    output s0_req_ready, s0_rsp_valid, s0_rsp_rdata,
    input  s1_req_valid, s1_req_wen, s1_req_addr, s1_req_wdata,
    output s1_req_ready, s1_rsp_valid, s1_rsp_rdata,
    output m_en, m_wen, m_addr, m_din,
    input  m_dout
  );

  modport master (
    output s0_req_valid, s0_req_wen, s0_req_addr, s0_req_wdata,
    input  s0_req_ready, s0_rsp_valid, s0_rsp_rdata,
    output s1_req_valid, s1_req_wen, s1_req_addr, s1_req_wdata,
    input  s1_req_ready, s1_rsp_valid, s1_rsp_rdata,
    input  m_en, m_wen, m_addr, m_din,
    output m_dout
  );
endinterface

// File: rtl/bram_sp_arbiter.sv
// Two-client arbiter for one single-port block RAM with read-response routing
// and a clear sequencer that fills the whole memory with a constant.
module bram_sp_arbiter #(
  parameter int unsigned          MEM_WIDTH     = 32,
  parameter int unsigned          MEM_DEPTH     = 4096,
  parameter int unsigned          READ_LATENCY  = 2,
  parameter string                ARB_MODE      = "ROUND_ROBIN",
  parameter string                INIT_ON_RESET = "true",
  parameter logic [MEM_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_start,
  output logic clr_busy,
  bram_sp_arbiter_if.slave bus
);

  localparam int unsigned AW          = $clog2(MEM_DEPTH - 1) + 1;
  localparam bit          FIXED_ARB   = (ARB_MODE == "FIXED");
  localparam bit          INIT_ON_RST = (INIT_ON_RESET == "true");

  typedef enum logic {ST_CLEAR, ST_ARB} state_t;

  state_t                  r_state;
  logic [AW-1:0]           r_clr_cnt;
  logic                    r_rr_ptr;
  logic [READ_LATENCY-1:0] r_tag_vld;
  logic [READ_LATENCY-1:0] r_tag_ch;

  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_any;
  logic w_gnt_wen;

  // Grant: a pending clear pre-empts every request in the same cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == ST_ARB && !clr_start) begin
      if (bus.s0_req_valid && bus.s1_req_valid) begin
        if (FIXED_ARB || !r_rr_ptr) w_gnt0 = 1'b1;
        else                        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = bus.s0_req_valid;
        w_gnt1 = bus.s1_req_valid;
      end
    end
  end

  assign w_gnt_any        = w_gnt0 | w_gnt1;
  assign w_gnt_wen        = w_gnt0 ? bus.s0_req_wen : bus.s1_req_wen;
  assign bus.s0_req_ready = w_gnt0;
  assign bus.s1_req_ready = w_gnt1;
  assign clr_busy         = (r_state == ST_CLEAR);

  // RAM port: sweep writes while clearing, otherwise the granted channel.
  always_comb begin
    bus.m_en   = 1'b0;
    bus.m_wen  = 1'b0;
    bus.m_addr = '0;
    bus.m_din  = '0;
    if (r_state == ST_CLEAR) begin
      bus.m_en   = 1'b1;
      bus.m_wen  = 1'b1;
      bus.m_addr = r_clr_cnt;
      bus.m_din  = INIT_VALUE;
    end else if (w_gnt0) begin
      bus.m_en   = 1'b1;
      bus.m_wen  = bus.s0_req_wen;
      bus.m_addr = bus.s0_req_addr;
      bus.m_din  = bus.s0_req_wdata;
    end else if (w_gnt1) begin
      bus.m_en   = 1'b1;
      bus.m_wen  = bus.s1_req_wen;
      bus.m_addr = bus.s1_req_addr;
      bus.m_din  = bus.s1_req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= INIT_ON_RST ? ST_CLEAR : ST_ARB;
      r_clr_cnt <= '0;
      r_rr_ptr  <= 1'b0;
      r_tag_vld <= '0;
      r_tag_ch  <= '0;
    end else begin
      if (r_state == ST_CLEAR) begin
        if (r_clr_cnt == AW'(MEM_DEPTH - 1)) begin
          r_state   <= ST_ARB;
          r_clr_cnt <= '0;
        end else begin
          r_clr_cnt <= r_clr_cnt + AW'(1);
        end
      end else if (clr_start) begin
        r_state <= ST_CLEAR;
      end

      // Pointer favours the channel that lost (or was idle) last time.
      if (w_gnt_any) r_rr_ptr <= w_gnt0;

      // Tag pipeline mirrors the RAM read latency; writes enter as bubbles.
      r_tag_vld[0] <= w_gnt_any & ~w_gnt_wen;
      r_tag_ch[0]  <= w_gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_ch[i]  <= r_tag_ch[i-1];
      end
    end
  end

  assign bus.s0_rsp_valid = r_tag_vld[READ_LATENCY-1] & ~r_tag_ch[READ_LATENCY-1];
  assign bus.s1_rsp_valid = r_tag_vld[READ_LATENCY-1] &  r_tag_ch[READ_LATENCY-1];
  assign bus.s0_rsp_rdata = bus.m_dout;
  assign bus.s1_rsp_rdata = bus.m_dout;

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Scoreboard bench: dut_a is round-robin, latency 2, clear on reset;
// dut_b is fixed priority, latency 1, no clear on reset.
module tb_bram_sp_arbiter;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH - 1) + 1;
  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 1;
  localparam logic [DW-1:0] FILL = 32'h0000_00A5;

  typedef struct packed {
    logic          ch;
    logic [DW-1:0] data;
    logic [31:0]   due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, clr_a, clr_b, busy_a, busy_b;
  int   n_checks = 0;
  int   n_errors = 0;

  bram_sp_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
  bram_sp_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

  bram_sp_arbiter #(.MEM_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(LAT_A),
    .ARB_MODE("ROUND_ROBIN"), .INIT_ON_RESET("true"), .INIT_VALUE(FILL)) dut_a (
    .clk(clk), .rst(rst_a), .clr_start(clr_a), .clr_busy(busy_a), .bus(bus_a.slave));

  bram_sp_arbiter #(.MEM_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(LAT_B),
    .ARB_MODE("FIXED"), .INIT_ON_RESET("false"), .INIT_VALUE('0)) dut_b (
    .clk(clk), .rst(rst_b), .clr_start(clr_b), .clr_busy(busy_b), .bus(bus_b.slave));

  // RAM models: A has an extra output register, B reads in one clock.
  logic [DW-1:0] ram_a [DEPTH];
  logic [DW-1:0] ram_b [DEPTH];
  logic [DW-1:0] ra1, ra2, rb1;

  always @(posedge clk) begin
    if (bus_a.m_en &&  bus_a.m_wen) ram_a[bus_a.m_addr[3:0]] <= bus_a.m_din;
    if (bus_a.m_en && !bus_a.m_wen) ra1 <= ram_a[bus_a.m_addr[3:0]];
    ra2 <= ra1;
    if (bus_b.m_en &&  bus_b.m_wen) ram_b[bus_b.m_addr[3:0]] <= bus_b.m_din;
    if (bus_b.m_en && !bus_b.m_wen) rb1 <= ram_b[bus_b.m_addr[3:0]];
  end
  assign bus_a.m_dout = ra2;
  assign bus_b.m_dout = rb1;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboards: predict at the negedge before the accepting edge, compare at due negedge.
  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] mdl_a [DEPTH];
  logic [DW-1:0] mdl_b [DEPTH];
  logic          rr_a;
  logic [31:0]   cyc_a = 0;
  logic [31:0]   cyc_b = 0;

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_a++;
      if (q_a.size() > 0 && q_a[0].due == cyc_a) begin
        e = q_a.pop_front();
        check("a_rsp_vld", DW'({bus_a.s1_rsp_valid, bus_a.s0_rsp_valid}), e.ch ? DW'(2) : DW'(1));
        check("a_rsp_data", e.ch ? bus_a.s1_rsp_rdata : bus_a.s0_rsp_rdata, e.data);
      end else if (bus_a.s0_rsp_valid || bus_a.s1_rsp_valid) begin
        check("a_rsp_spurious", DW'({bus_a.s1_rsp_valid, bus_a.s0_rsp_valid}), '0);
      end
      if (rst_a) begin
        q_a.delete();
        rr_a = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_a[i] = FILL;
      end else begin
        if (bus_a.s0_req_valid && bus_a.s1_req_valid && (bus_a.s0_req_ready || bus_a.s1_req_ready))
          check("a_rr_grant", DW'({bus_a.s1_req_ready, bus_a.s0_req_ready}), rr_a ? DW'(2) : DW'(1));
        if (bus_a.s0_req_valid && bus_a.s0_req_ready) begin
          if (bus_a.s0_req_wen) mdl_a[bus_a.s0_req_addr[3:0]] = bus_a.s0_req_wdata;
          else q_a.push_back('{ch: 1'b0, data: mdl_a[bus_a.s0_req_addr[3:0]], due: cyc_a + LAT_A});
          rr_a = 1'b1;
        end
        if (bus_a.s1_req_valid && bus_a.s1_req_ready) begin
          if (bus_a.s1_req_wen) mdl_a[bus_a.s1_req_addr[3:0]] = bus_a.s1_req_wdata;
          else q_a.push_back('{ch: 1'b1, data: mdl_a[bus_a.s1_req_addr[3:0]], due: cyc_a + LAT_A});
          rr_a = 1'b0;
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_b++;
      if (q_b.size() > 0 && q_b[0].due == cyc_b) begin
        e = q_b.pop_front();
        check("b_rsp_vld", DW'({bus_b.s1_rsp_valid, bus_b.s0_rsp_valid}), e.ch ? DW'(2) : DW'(1));
        check("b_rsp_data", e.ch ? bus_b.s1_rsp_rdata : bus_b.s0_rsp_rdata, e.data);
      end else if (bus_b.s0_rsp_valid || bus_b.s1_rsp_valid) begin
        check("b_rsp_spurious", DW'({bus_b.s1_rsp_valid, bus_b.s0_rsp_valid}), '0);
      end
      if (rst_b) begin
        q_b.delete();
      end else begin
        if (bus_b.s0_req_valid && bus_b.s1_req_valid)
          check("b_fixed_grant", DW'({bus_b.s1_req_ready, bus_b.s0_req_ready}), DW'(1));
        if (bus_b.s0_req_valid && bus_b.s0_req_ready) begin
          if (bus_b.s0_req_wen) mdl_b[bus_b.s0_req_addr[3:0]] = bus_b.s0_req_wdata;
          else q_b.push_back('{ch: 1'b0, data: mdl_b[bus_b.s0_req_addr[3:0]], due: cyc_b + LAT_B});
        end
        if (bus_b.s1_req_valid && bus_b.s1_req_ready) begin
          if (bus_b.s1_req_wen) mdl_b[bus_b.s1_req_addr[3:0]] = bus_b.s1_req_wdata;
          else q_b.push_back('{ch: 1'b1, data: mdl_b[bus_b.s1_req_addr[3:0]], due: cyc_b + LAT_B});
        end
      end
    end
  end

  task automatic set_req(input bit sel, input bit ch, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!sel && !ch) begin
      bus_a.s0_req_valid = v; bus_a.s0_req_wen = w; bus_a.s0_req_addr = a; bus_a.s0_req_wdata = d;
    end else if (!sel) begin
      bus_a.s1_req_valid = v; bus_a.s1_req_wen = w; bus_a.s1_req_addr = a; bus_a.s1_req_wdata = d;
    end else if (!ch) begin
      bus_b.s0_req_valid = v; bus_b.s0_req_wen = w; bus_b.s0_req_addr = a; bus_b.s0_req_wdata = d;
    end else begin
      bus_b.s1_req_valid = v; bus_b.s1_req_wen = w; bus_b.s1_req_addr = a; bus_b.s1_req_wdata = d;
    end
  endtask

  function automatic logic got_ready(input bit sel, input bit ch);
    if (sel) return ch ? bus_b.s1_req_ready : bus_b.s0_req_ready;
    return ch ? bus_a.s1_req_ready : bus_a.s0_req_ready;
  endfunction

  // Issue n requests on one channel with valid held, address/data stepping per accept.
  task automatic stream(input bit sel, input bit ch, input logic w, input logic [AW-1:0] a0,
                        input int n, input logic [DW-1:0] d0);
    int   k = 0;
    int   guard = 0;
    logic acc;
    while (k < n) begin
      set_req(sel, ch, 1'b1, w, a0 + AW'(k), d0 + DW'(k));
      @(negedge clk);
      acc = got_ready(sel, ch);
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
      if (guard > 100) begin
        check("stream_timeout", DW'(k), DW'(n));
        break;
      end
    end
    set_req(sel, ch, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic sweep_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("a_sweep_busy", DW'(busy_a), DW'(1));
      check("a_sweep_addr", DW'(bus_a.m_addr), DW'(i));
      check("a_sweep_wen", DW'({bus_a.m_en, bus_a.m_wen}), DW'(3));
      check("a_sweep_rdy", DW'({bus_a.s1_req_ready, bus_a.s0_req_ready}), '0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    rst_a = 1'b1; rst_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++) set_req(1'(s), 1'(c), 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("a_rst_busy", DW'(busy_a), DW'(1));
    check("a_rst_mport", DW'({bus_a.m_en, bus_a.m_wen}), DW'(3));
    check("a_rst_addr", DW'(bus_a.m_addr), '0);
    check("a_rst_din", bus_a.m_din, FILL);
    check("a_rst_rsp", DW'({bus_a.s1_rsp_valid, bus_a.s0_rsp_valid}), '0);
    check("b_rst_busy", DW'(busy_b), '0);
    check("b_rst_men", DW'(bus_b.m_en), '0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Power-on sweep, then a read of the filled memory.
    sweep_a(DEPTH);
    @(negedge clk);
    check("a_sweep_done", DW'(busy_a), '0);
    @(posedge clk); #1;
    stream(0, 0, 1'b0, 5'd7, 1, '0);
    drain();

    // Write then read the same address on consecutive cycles, both latencies.
    stream(0, 0, 1'b1, 5'd3, 1, 32'h1234);
    stream(0, 0, 1'b0, 5'd3, 1, '0);
    stream(1, 0, 1'b1, 5'd3, 1, 32'h1234);
    stream(1, 0, 1'b0, 5'd3, 1, '0);
    drain();

    // Round-robin contention: writes then reads on both channels.
    fork
      stream(0, 0, 1'b1, 5'd0, 4, 32'h100);
      stream(0, 1, 1'b1, 5'd8, 4, 32'h200);
    join
    fork
      stream(0, 0, 1'b0, 5'd0, 4, '0);
      stream(0, 1, 1'b0, 5'd8, 4, '0);
    join
    drain();

    // Fixed priority contention on B.
    fork
      stream(1, 0, 1'b1, 5'd0, 4, 32'h300);
      stream(1, 1, 1'b1, 5'd8, 4, 32'h400);
    join
    fork
      stream(1, 0, 1'b0, 5'd0, 4, '0);
      stream(1, 1, 1'b0, 5'd8, 4, '0);
    join
    drain();

    // s1 read in flight, then clr_start together with an s0 request.
    stream(0, 1, 1'b0, 5'd8, 1, '0);
    clr_a = 1'b1;
    set_req(0, 0, 1'b1, 1'b0, 5'd7, '0);
    for (int i = 0; i < DEPTH; i++) mdl_a[i] = FILL;
    @(negedge clk);
    check("a_clr_nogrant", DW'({bus_a.m_en, bus_a.s0_req_ready}), '0);
    @(posedge clk); #1;
    clr_a = 1'b0;
    sweep_a(DEPTH);
    @(negedge clk);
    check("a_clr_done", DW'(busy_a), '0);
    check("a_clr_ready_back", DW'(bus_a.s0_req_ready), DW'(1));
    @(posedge clk); #1;
    set_req(0, 0, 1'b0, 1'b0, '0, '0);
    fork
      stream(0, 0, 1'b0, 5'd0, 4, '0);
      stream(0, 1, 1'b0, 5'd8, 4, '0);
    join
    drain();

    // Reset mid-read, then reset mid-sweep at address 9.
    stream(0, 0, 1'b0, 5'd3, 1, '0);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    sweep_a(9);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_rst_at9", DW'(bus_a.m_addr), DW'(9));
    @(posedge clk); #1;
    rst_a = 1'b0;
    sweep_a(DEPTH);
    @(negedge clk);
    check("a_resweep_done", DW'(busy_a), '0);
    @(posedge clk); #1;
    stream(0, 1, 1'b0, 5'd5, 1, '0);
    drain();

    check("a_queue_empty", DW'(q_a.size()), '0);
    check("b_queue_empty", DW'(q_b.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
